mem_wait_responder: RTL
=======================

Name: mem_wait_responder

Overview:
- Memory-side responder for the CPU data/instruction bus: accepts word read/write requests over a req/ack handshake.
- Performs each access after a programmable number of wait states and returns read data with a one-cycle ack pulse.
- Sits between a handshaking multi-cycle CPU core and a word-addressed RAM array held inside the block.
- Used to model and stress slow memory so the control unit can be made stall-aware.

Parameters:
- DEPTH, 64, number of 32-bit words in the internal array; must be a power of two, 4 to 1024.
- WAIT_CYCLES, 2, wait states inserted between request capture and ack; 0 to 15.
- DW, 32, data width in bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rstn  input  1  synchronous active-low reset.
- req  input  1  request valid; held high by the requester until ack is seen.
- we  input  1  1 = write, 0 = read; sampled with req.
- addr  input  32  byte address; word index is addr[log2(DEPTH)+1:2]; addr[1:0] is ignored.
- wd  input  DW  write data; sampled with req.
- rd  output  DW  read data; valid in the ack cycle and held until the next read ack.
- ack  output  1  one-cycle completion pulse.
- busy  output  1  high from request capture through the ack cycle.
- err  output  1  (MEM_RESP_ERR_EN only) out-of-range flag, valid with ack.

Behaviour:
- Reset (rstn=0 at a rising edge): state goes to IDLE; ack=0, busy=0, rd=0, err=0; wait counter=0.
  - Array contents are not affected by reset.
  - A transaction in flight when reset is asserted is abandoned and its write is not performed.
- States: IDLE, WAIT, RESP.
- IDLE, req=1 at an edge:
  - Latch addr, we and wd into internal registers; set busy=1.
  - If WAIT_CYCLES=0, go to RESP; otherwise go to WAIT with counter loaded to WAIT_CYCLES-1.
- IDLE, req=0: remain in IDLE.
- WAIT:
  - Counter decrements each cycle.
  - At counter=0, go to RESP.
  - Input changes during WAIT are ignored; only the latched request is used.
- RESP (one cycle):
  - ack=1, busy=1.
  - Read: rd is driven from array[latched index].
  - Write: array[latched index] <= latched wd at the end of this cycle; rd is unchanged.
  - Next state is IDLE.
- Latency: ack is asserted exactly WAIT_CYCLES+1 cycles after the edge at which req was captured.
  - WAIT_CYCLES=0 gives ack in the cycle immediately after capture.
- Back-to-back: if req is still high in the IDLE cycle after ack, a new request is captured.
  - Minimum request-to-request spacing is WAIT_CYCLES+2 cycles.
- Read-after-write to the same address in the next transaction returns the newly written value.
- ack never asserts outside RESP, and never for two consecutive cycles.
- Address width: indexing uses only the log2(DEPTH) bits above addr[1:0]; the upper bits are handled per the Optional Feature.

Optional Feature:
- Macro: MEM_RESP_ERR_EN.
- Defined:
  - Port err exists.
  - If any latched addr bit above log2(DEPTH)+1 is set, the access is out of range: err=1 in the RESP cycle, a read returns rd=0, and a write is dropped.
  - err=0 in all other cycles, and in RESP for in-range accesses.
- Not defined:
  - Port err is absent.
  - Upper address bits are ignored, so addresses wrap modulo DEPTH*4 bytes.

Test Plan:
- Write then read: WAIT_CYCLES=2; write addr=0x08, wd=0xDEADBEEF, then read addr=0x08 -> both acks 3 cycles after capture; read rd=0xDEADBEEF.
- Zero wait: WAIT_CYCLES=0; read addr=0x00 after writing 0x12345678 -> ack in the cycle after capture, rd=0x12345678, busy high for exactly 1 cycle.
- Held request: req held high across 4 transactions -> acks spaced exactly WAIT_CYCLES+2 cycles apart, each ack exactly 1 cycle wide.
- Mid-WAIT reset: reset asserted during WAIT of a write of 0xCAFEF00D to 0x10, then 0x10 is read -> ack/busy/rd=0 after reset, no ack for the aborted write, 0x10 still holds its old value.
- Out of range, DEPTH=64, MEM_RESP_ERR_EN defined: write 0xAAAA5555 to addr 0x100 -> err=1 with ack; read 0x100 returns rd=0 with err=1; read 0x000 returns its prior contents.
- Wrap, DEPTH=64, MEM_RESP_ERR_EN undefined: write 0xAAAA5555 to addr 0x100, read 0x000 -> rd=0xAAAA5555.
- Input stability: change addr and wd during WAIT -> the access uses the values latched at capture.

Source files
------------

// File: rtl/mem_wait_responder_if.sv
// Request/response bus between a CPU core (master) and mem_wait_responder (slave).
// Optional macro MEM_RESP_ERR_EN adds the out-of-range flag err.
interface mem_wait_responder_if #(
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [31:0]   addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
    logic          ack;
    logic          busy;
`ifdef MEM_RESP_ERR_EN
    logic          err;
`endif

    modport master (
        output req, we, addr, wd,
`ifdef MEM_RESP_ERR_EN
        input  err,
`endif
        input  rd, ack, busy
    );

    modport slave (
        input  req, we, addr, wd,
`ifdef MEM_RESP_ERR_EN
        output err,
`endif
        output rd, ack, busy
    );
endinterface

// File: rtl/mem_wait_responder.sv
// Word-addressed RAM responder with programmable wait states and req/ack handshake.
// Optional macro MEM_RESP_ERR_EN: flag accesses with address bits above the array
// range (err with ack, read returns 0, write dropped); otherwise addresses wrap.
module mem_wait_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int DW          = 32
) (
    input logic                 clk,
    input logic                 rstn,
    mem_wait_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q,   cnt_d;
    logic [AW-1:0] idx_q,   idx_d;
    logic          we_q,    we_d;
    logic [DW-1:0] wd_q,    wd_d;
    logic [DW-1:0] rd_q,    rd_d;
    logic          oor_q,   oor_d;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_rdata;
    logic          addr_oor;

    assign mem_rdata = mem_q[idx_q];

`ifdef MEM_RESP_ERR_EN
    assign addr_oor = |bus.addr[31:AW+2];
`else
    assign addr_oor = 1'b0;
`endif

    // Next-state, request capture, wait countdown and read-data selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        oor_d   = oor_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    idx_d = bus.addr[AW+1:2];
                    we_d  = bus.we;
                    wd_d  = bus.wd;
                    oor_d = addr_oor;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (!we_q) begin
                    rd_d = oor_q ? '0 : mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // rd_d already carries the fresh read word during RESP, so rd is valid in the
    // ack cycle and then held by rd_q until the next read completes.
    assign bus.rd   = rd_d;
    assign bus.ack  = (state_q == RESP);
    assign bus.busy = (state_q != IDLE);
`ifdef MEM_RESP_ERR_EN
    assign bus.err  = (state_q == RESP) && oor_q;
`endif

    // Control and latched-request registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wd_q    <= '0;
            rd_q    <= '0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            oor_q   <= oor_d;
        end
    end

    // Array write at the end of RESP; untouched by reset, and a reset edge aborts it.
    always_ff @(posedge clk) begin
        if (rstn && (state_q == RESP) && we_q && !oor_q) begin
            mem_q[idx_q] <= wd_q;
        end
    end
endmodule
